// File: rtl/issue_scoreboard.sv
// Dual-issue hazard scoreboard beside ID.
// Tracks pending writes, gates issue, drives forwarding flags.
module issue_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid_1,
  input  logic          id_valid_2,
  input  logic [AW-1:0] id_rs1_1,
  input  logic [AW-1:0] id_rs2_1,
  input  logic [AW-1:0] id_rs1_2,
  input  logic [AW-1:0] id_rs2_2,
  input  logic [AW-1:0] id_rd_1,
  input  logic [AW-1:0] id_rd_2,
  input  logic          id_wen_1,
  input  logic          id_wen_2,
  input  logic          id_load_1,
  input  logic          id_load_2,
  input  logic          pipe_freeze,
  input  logic          flush,
  output logic          issue_1,
  output logic          issue_2,
  output logic          stall_id,
  output logic          ex_ex_finish_1,
  output logic          mem_ex_finish_1,
  output logic          mem_ex_finish_2,
  output logic          mem_mem_finish_1,
  output logic          mem_mem_finish_2
);

  typedef struct packed {
    logic v;
    logic wen;
    logic ld;
  } shd_t;

  logic [1:0] cnt_q [NREG];
  logic [1:0] cnt_d [NREG];

  shd_t ex1_q, ex2_q;
  shd_t mem1_q, mem2_q;
  shd_t ex1_d, ex2_d;

  logic rdy11, rdy21, rdy12, rdy22;
  logic wr1, wr2, dep12;
  logic iss1, iss2;

  // Source readiness and issue decision for both slots
  always_comb begin
    rdy11 = (id_rs1_1 == '0) || (cnt_q[id_rs1_1] <= 2'd1);
    rdy21 = (id_rs2_1 == '0) || (cnt_q[id_rs2_1] <= 2'd1);
    rdy12 = (id_rs1_2 == '0) || (cnt_q[id_rs1_2] <= 2'd1);
    rdy22 = (id_rs2_2 == '0) || (cnt_q[id_rs2_2] <= 2'd1);
    wr1   = id_wen_1 & (id_rd_1 != '0);
    wr2   = id_wen_2 & (id_rd_2 != '0);
    // only a load in slot 1 can starve slot 2;
    // ALU results reach slot 2 via ex_ex forwarding
    dep12 = wr1 & id_load_1 &
            ((id_rd_1 == id_rs1_2) |
             (id_rd_1 == id_rs2_2));
    iss1  = id_valid_1 & ~flush & ~pipe_freeze &
            rdy11 & rdy21;
    iss2  = iss1 & id_valid_2 & rdy12 & rdy22 &
            ~dep12;
  end

  assign issue_1  = iss1;
  assign issue_2  = iss2;
  assign stall_id = id_valid_1 & ~iss1 & ~flush;

  // Countdown next state; fresh writes override the decrement
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != 2'd0) ?
                 cnt_q[r] - 2'd1 : 2'd0;
    end
    if (iss1 && wr1)
      cnt_d[id_rd_1] = id_load_1 ? 2'd2 : 2'd1;
    // slot 2 is younger, so its value wins on same rd
    if (iss2 && wr2)
      cnt_d[id_rd_2] = id_load_2 ? 2'd2 : 2'd1;
    cnt_d[0] = 2'd0;
  end

  // EX shadow captures issued slots, bubbles otherwise
  always_comb begin
    ex1_d = '0;
    ex2_d = '0;
    if (iss1) ex1_d = '{v: 1'b1, wen: wr1, ld: id_load_1};
    if (iss2) ex2_d = '{v: 1'b1, wen: wr2, ld: id_load_2};
  end

  // State register; freeze holds everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= 2'd0;
      ex1_q  <= '0;
      ex2_q  <= '0;
      mem1_q <= '0;
      mem2_q <= '0;
    end else if (!pipe_freeze) begin
      cnt_q  <= cnt_d;
      ex1_q  <= ex1_d;
      ex2_q  <= ex2_d;
      mem1_q <= ex1_q;
      mem2_q <= ex2_q;
    end
  end

  assign ex_ex_finish_1   = ex1_q.v & ex1_q.wen & ~ex1_q.ld;
  assign mem_ex_finish_1  = mem1_q.v & mem1_q.wen & ~mem1_q.ld;
  assign mem_ex_finish_2  = mem2_q.v & mem2_q.wen & ~mem2_q.ld;
  assign mem_mem_finish_1 = mem1_q.v & mem1_q.wen & mem1_q.ld;
  assign mem_mem_finish_2 = mem2_q.v & mem2_q.wen & mem2_q.ld;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard.
// Expectations queued at drive time, popped at sample time.
module tb_issue_scoreboard;

  logic       clk, rst_n;
  logic       v1, v2;
  logic [4:0] rs11, rs21, rs12, rs22, rd1, rd2;
  logic       w1, w2, l1, l2;
  logic       frz, fl;
  logic       i1, i2, st, exf, mef1, mef2, mmf1, mmf2;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  issue_scoreboard dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_valid_1       (v1),
    .id_valid_2       (v2),
    .id_rs1_1         (rs11),
    .id_rs2_1         (rs21),
    .id_rs1_2         (rs12),
    .id_rs2_2         (rs22),
    .id_rd_1          (rd1),
    .id_rd_2          (rd2),
    .id_wen_1         (w1),
    .id_wen_2         (w2),
    .id_load_1        (l1),
    .id_load_2        (l2),
    .pipe_freeze      (frz),
    .flush            (fl),
    .issue_1          (i1),
    .issue_2          (i2),
    .stall_id         (st),
    .ex_ex_finish_1   (exf),
    .mem_ex_finish_1  (mef1),
    .mem_ex_finish_2  (mef2),
    .mem_mem_finish_1 (mmf1),
    .mem_mem_finish_2 (mmf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic s1(input logic v, input logic [4:0] a,
                    input logic [4:0] b, input logic [4:0] d,
                    input logic w, input logic l);
    v1 = v; rs11 = a; rs21 = b; rd1 = d; w1 = w; l1 = l;
  endtask

  task automatic s2(input logic v, input logic [4:0] a,
                    input logic [4:0] b, input logic [4:0] d,
                    input logic w, input logic l);
    v2 = v; rs12 = a; rs22 = b; rd2 = d; w2 = w; l2 = l;
  endtask

  task automatic idle();
    s1(0, 0, 0, 0, 0, 0);
    s2(0, 0, 0, 0, 0, 0);
  endtask

  // vector: i1 i2 stall exf mef1 mef2 mmf1 mmf2
  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t       e;
    logic [7:0] obs;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL empty_queue obs=none exp=entry");
    end else begin
      e   = q.pop_front();
      obs = {i1, i2, st, exf, mef1, mef2, mmf1, mmf2};
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s obs=%b exp=%b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [7:0] v);
    push(tag, v);
    #1;
    pop_chk();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; frz = 0; fl = 0;
    idle();
    cmp("reset", 8'b000_00000);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ADD x5 / SUB x6,x5 dual issue
    s1(1, 1, 2, 5, 1, 0);
    s2(1, 5, 1, 6, 1, 0);
    cmp("alu_pair", 8'b110_00000);
    tick(); idle();
    cmp("alu_ex", 8'b000_10000);
    tick();
    cmp("alu_mem", 8'b000_01100);
    tick();
    cmp("alu_drain", 8'b000_00000);

    // LW x5 then ADD x7,x5 load-use
    s1(1, 1, 0, 5, 1, 1);
    cmp("lw_issue", 8'b100_00000);
    tick(); s1(1, 5, 0, 7, 1, 0);
    cmp("lu_stall", 8'b001_00000);
    tick();
    cmp("lu_issue", 8'b100_00010);
    tick(); idle();
    cmp("lu_ex", 8'b000_10000);
    tick();
    cmp("lu_mem", 8'b000_01000);
    tick();

    // LW x5 / ADD x8,x5 split pair
    s1(1, 1, 0, 5, 1, 1);
    s2(1, 5, 0, 8, 1, 0);
    cmp("split", 8'b100_00000);
    tick();
    s1(1, 5, 0, 8, 1, 0);
    s2(0, 0, 0, 0, 0, 0);
    cmp("split_stall", 8'b001_00000);
    tick();
    cmp("split_issue", 8'b100_00010);
    tick(); idle();
    cmp("split_ex", 8'b000_10000);
    tick();
    cmp("split_mem", 8'b000_01000);
    tick();

    // LW x9 / ADD x9 same rd: slot 2 value wins
    s1(1, 1, 0, 9, 1, 1);
    s2(1, 2, 0, 9, 1, 0);
    cmp("waw_pair", 8'b110_00000);
    tick();
    s1(1, 9, 0, 10, 1, 0);
    s2(0, 0, 0, 0, 0, 0);
    cmp("waw_use", 8'b100_00000);
    tick(); idle();
    cmp("waw_mem", 8'b000_10110);
    tick();
    cmp("waw_drain", 8'b000_01000);
    tick();

    // freeze after LW issue
    s1(1, 1, 0, 5, 1, 1);
    cmp("frz_lw", 8'b100_00000);
    tick();
    frz = 1;
    s1(1, 5, 0, 7, 1, 0);
    cmp("frz_0", 8'b001_00000);
    tick();
    cmp("frz_1", 8'b001_00000);
    tick();
    cmp("frz_2", 8'b001_00000);
    tick();
    cmp("frz_3", 8'b001_00000);
    frz = 0;
    cmp("frz_rel", 8'b001_00000);
    tick();
    cmp("frz_issue", 8'b100_00010);
    tick(); idle();
    cmp("frz_ex", 8'b000_10000);
    tick();
    cmp("frz_mem", 8'b000_01000);
    tick();

    // flush of a load pair, then x0 writes
    fl = 1;
    s1(1, 1, 0, 11, 1, 1);
    s2(1, 2, 0, 12, 1, 1);
    cmp("flush", 8'b000_00000);
    tick();
    fl = 0;
    s1(1, 11, 12, 13, 1, 0);
    s2(0, 0, 0, 0, 0, 0);
    cmp("post_flush", 8'b100_00000);
    tick();
    s1(1, 1, 0, 0, 1, 1);
    s2(1, 0, 0, 14, 1, 0);
    cmp("x0_pair", 8'b110_10000);
    tick(); idle();
    cmp("x0_ex", 8'b000_01000);
    tick();
    cmp("x0_mem", 8'b000_00100);
    tick();

    // async reset mid-operation forgets the load
    s1(1, 1, 0, 5, 1, 1);
    cmp("rst_lw", 8'b100_00000);
    tick(); idle();
    rst_n = 1'b0;
    cmp("rst_async", 8'b000_00000);
    rst_n = 1'b1;
    s1(1, 5, 0, 7, 1, 0);
    cmp("rst_use", 8'b100_00000);
    tick(); idle();
    cmp("rst_ex", 8'b000_10000);

    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL leftover obs=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
